// File: rtl/pc_gen_pkg.sv
// Shared defaults and types for the next-PC generator and its return-address stack.
package pc_gen_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_INSTR_BYTES = 4;
  localparam int DEF_RAS_DEPTH   = 4;
  localparam int DEF_EPOCH_W     = 2;

  // Source that produced the current pc; exported so checkers can see which path won.
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_SEQ,
    SEL_RAS,
    SEL_REDIR,
    SEL_EXC
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect requests and decode hints in, fetch pc and RAS status out.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int EPOCH_W = 2
);
  import pc_gen_pkg::*;

  logic               pc_stall;
  logic               exc_valid;
  logic [ADDR_W-1:0]  exc_vector;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_target;
  logic               ras_push;
  logic [ADDR_W-1:0]  ras_push_addr;
  logic               ras_pop;
  logic               fetch_ready;
  logic               fetch_valid;
  logic [ADDR_W-1:0]  pc;
  logic [EPOCH_W-1:0] pc_epoch;
  logic               ras_empty;
  logic               ras_full;
  logic               ras_underflow;
  pc_sel_e            last_sel;

  // Handshake: a fetch of pc completes on an edge where fetch_valid & fetch_ready & ~pc_stall;
  // otherwise pc/pc_epoch hold unless a redirect (exception, EX redirect, RAS return) is taken.
  modport master (
    input  pc_stall, exc_valid, exc_vector, redir_valid, redir_target,
           ras_push, ras_push_addr, ras_pop, fetch_ready,
    output fetch_valid, pc, pc_epoch, ras_empty, ras_full, ras_underflow, last_sel
  );

  modport slave (
    output pc_stall, exc_valid, exc_vector, redir_valid, redir_target,
           ras_push, ras_push_addr, ras_pop, fetch_ready,
    input  fetch_valid, pc, pc_epoch, ras_empty, ras_full, ras_underflow, last_sel
  );

endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_gen_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;
  logic              pop_ok;

  assign top    = mem[ptr];
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop_ok = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr       <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop & empty;
      if (push && pop_ok) begin
        // Return consumes the old top; the new call address takes its slot.
        mem[ptr] <= push_addr;
      end else if (push) begin
        mem[ptr + PTR_W'(1)] <= push_addr;
        ptr <= ptr + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop_ok) begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: priority redirect mux (exception > EX redirect > RAS return > sequential),
// epoch tag for wrong-path filtering, and fetch_valid handshake.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int                RAS_DEPTH   = DEF_RAS_DEPTH,
  parameter int                EPOCH_W     = DEF_EPOCH_W
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

  logic [ADDR_W-1:0]  pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               fv_q;
  pc_sel_e            sel, sel_q;

  logic               hints_ok, fire;
  logic [ADDR_W-1:0]  ras_top;
  logic               ras_empty, ras_full, ras_underflow;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  // Decode hints belong to the wrong path whenever an older stage redirects.
  assign hints_ok = ~bus.exc_valid & ~bus.redir_valid;
  assign fire     = fv_q & bus.fetch_ready & ~bus.pc_stall;

  pc_gen_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.exc_valid),
    .push      (bus.ras_push & hints_ok),
    .push_addr (bus.ras_push_addr),
    .pop       (bus.ras_pop & hints_ok),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .underflow (ras_underflow)
  );

  always_comb begin
    sel = SEL_HOLD;
    if (bus.exc_valid)                 sel = SEL_EXC;
    else if (bus.redir_valid)          sel = SEL_REDIR;
    else if (bus.ras_pop && !ras_empty) sel = SEL_RAS;
    else if (fire)                     sel = SEL_SEQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      epoch_q <= '0;
      fv_q    <= 1'b0;
      sel_q   <= SEL_RESET;
    end else begin
      fv_q  <= 1'b1;
      sel_q <= sel;
      case (sel)
        SEL_EXC: begin
          pc_q    <= align(bus.exc_vector);
          epoch_q <= epoch_q + EPOCH_W'(1);
        end
        SEL_REDIR: begin
          pc_q    <= align(bus.redir_target);
          epoch_q <= epoch_q + EPOCH_W'(1);
        end
        SEL_RAS: begin
          pc_q    <= align(ras_top);
          epoch_q <= epoch_q + EPOCH_W'(1);
        end
        SEL_SEQ: pc_q <= pc_q + STEP;
        default: ;
      endcase
    end
  end

  assign bus.fetch_valid   = fv_q;
  assign bus.pc            = pc_q;
  assign bus.pc_epoch      = epoch_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_underflow = ras_underflow;
  assign bus.last_sel      = sel_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen: each row is one clock of inputs plus the outputs expected after it.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.ADDR_W(32), .EPOCH_W(2)) bus ();

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(4), .EPOCH_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        ex;
    logic [31:0] exv;
    logic        rd;
    logic [31:0] rdt;
    logic        pu;
    logic [31:0] pa;
    logic        po;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        em;
    logic        fu;
    logic        uf;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];

  function automatic vec_t mk(input logic st, ex, input logic [31:0] exv, input logic rd,
                              input logic [31:0] rdt, input logic pu, input logic [31:0] pa,
                              input logic po, rdy, fv, input logic [31:0] pc,
                              input logic [1:0] ep, input logic em, fu, uf);
    vec_t v;
    v.i = '{st: st, ex: ex, exv: exv, rd: rd, rdt: rdt, pu: pu, pa: pa, po: po, rdy: rdy};
    v.o = '{fv: fv, pc: pc, ep: ep, em: em, fu: fu, uf: uf};
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{fv: bus.fetch_valid, pc: bus.pc, ep: bus.pc_epoch,
          em: bus.ras_empty, fu: bus.ras_full, uf: bus.ras_underflow};
    return o;
  endfunction

  // driver tasks
  task automatic drive(input in_t i);
    bus.pc_stall      = i.st;
    bus.exc_valid     = i.ex;
    bus.exc_vector    = i.exv;
    bus.redir_valid   = i.rd;
    bus.redir_target  = i.rdt;
    bus.ras_push      = i.pu;
    bus.ras_push_addr = i.pa;
    bus.ras_pop       = i.po;
    bus.fetch_ready   = i.rdy;
  endtask

  // scoreboard: compare DUT outputs against the head of exp_q
  task automatic check(input string name);
    out_t act, exp;
    act = sample();
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fv=%b pc=%h ep=%0d em=%b fu=%b uf=%b, expected fv=%b pc=%h ep=%0d em=%b fu=%b uf=%b",
               name, act.fv, act.pc, act.ep, act.em, act.fu, act.uf,
               exp.fv, exp.pc, exp.ep, exp.em, exp.fu, exp.uf);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.i);
    exp_q.push_back(v.o);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    drive('0);

    // T1: reset held two cycles
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{fv: 1'b0, pc: 32'h0, ep: 2'd0, em: 1'b1, fu: 1'b0, uf: 1'b0});
      @(posedge clk);
      #1;
      check($sformatf("reset[%0d]", k));
    end
    rst = 1'b0;

    //                   st ex exv          rd rdt          pu pa           po rdy  fv pc           ep em fu uf
    // T1 sequential fetch
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h0,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h4,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h8,       0, 1, 0, 0));
    // T2 not-ready then stall hold pc=8
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 0,   1, 32'h8,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 0,   1, 32'h8,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 0,   1, 32'h8,       0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h8,       0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h8,       0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'hC,       0, 1, 0, 0));
    // T3 exception beats redirect under stall, flushes RAS, ignores push
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h80,      0, 0,   1, 32'hC,       0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h100,     1, 32'h200,     1, 32'h90,      0, 1,   1, 32'h100,     1, 1, 0, 0));
    // T4 fill past depth, pop newest four, then underflow
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h10,      0, 0,   1, 32'h100,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h20,      0, 0,   1, 32'h100,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h30,      0, 0,   1, 32'h100,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h40,      0, 0,   1, 32'h100,     1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h50,      0, 0,   1, 32'h100,     1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h50,      2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h40,      3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h30,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h20,      1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h20,      1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 0,   1, 32'h20,      1, 1, 0, 0));
    // pop on empty falls through to sequential fetch
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 1,   1, 32'h24,      1, 1, 0, 1));
    // push+pop on empty: underflow and push lands
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h60,      1, 0,   1, 32'h24,      1, 0, 0, 1));
    // push+pop non-empty: redirect to old top, new addr replaces it
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h70,      1, 0,   1, 32'h60,      2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h70,      3, 1, 0, 0));
    // T5 redirect squashes decode hints; misaligned targets
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       1, 32'h88,      0, 0,   1, 32'h70,      3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       1, 32'h300,     1, 32'hAA,      1, 0,   1, 32'h300,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       1, 32'h303,     0, 32'h0,       0, 0,   1, 32'h300,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 0,   1, 32'h88,      2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h107,     0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h104,     3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 1,   1, 32'h108,     3, 1, 0, 0));

    foreach (vecs[n]) apply(vecs[n], $sformatf("vec[%0d]", n));

    // T6: address wrap, then epoch wrap over four redirects
    apply(mk(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 0, 0), "wrap_setup");
    apply(mk(0, 0, 32'h0, 0, 32'h0,         0, 32'h0, 0, 1, 1, 32'h0,         0, 1, 0, 0), "wrap_fire");
    for (int k = 1; k <= 4; k++) begin
      apply(mk(0, 0, 32'h0, 1, 32'h400 + 32'(k * 16), 0, 32'h0, 0, 0,
               1, 32'h400 + 32'(k * 16), 2'(k), 1, 0, 0), $sformatf("epoch_wrap[%0d]", k));
    end

    // reset wins over a simultaneous redirect
    rst = 1'b1;
    apply(mk(0, 0, 32'h0, 1, 32'h500, 1, 32'h44, 0, 1, 0, 32'h0, 0, 1, 0, 0), "rst_mid_redir");
    rst = 1'b0;
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 1, 0, 0), "post_rst_valid");
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h4, 0, 1, 0, 0), "post_rst_fire");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
